// File: rtl/reset_sequencer_if.sv
// Stage-side bundle of the reset sequencer: per-stage reset/ack pairs plus status.
// The sequencer uses the master modport; the subsystem side uses the slave modport.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    localparam int CW = $clog2(NUM_STAGES) + 1;

    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_rst;
    logic [CW-1:0]         cur_stage;
    logic                  sys_ready;
    logic                  timeout_err;

    modport master (
        input  stage_ack,
        output stage_rst,
        output cur_stage,
        output sys_ready,
        output timeout_err
    );

    modport slave (
        output stage_ack,
        input  stage_rst,
        input  cur_stage,
        input  sys_ready,
        input  timeout_err
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one at a time, gated by each stage's ack.
// Optional macro RESET_SEQUENCER_ACK_LOSS_REARM_EN: any ack loss in RUN restarts the sequence.
module reset_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_rst,
    reset_sequencer_if.master seq
);
    localparam int CW = $clog2(NUM_STAGES) + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0]         ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [DW-1:0]         DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]         LAST_IDX  = CW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES  = '1;
    localparam logic [NUM_STAGES-1:0] TOP_BIT   = NUM_STAGES'(1) << (NUM_STAGES - 1);

    typedef enum logic [1:0] {HOLD, WAIT_ACK, RUN} state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_meta_reg;
    logic                   btn_sync_reg;
    logic                   deb_reg;
    logic [DW-1:0]          deb_cnt_reg;
    logic [HW-1:0]          hold_cnt_reg;
    logic [AW-1:0]          ack_tmr_reg;
    logic [NUM_STAGES-1:0]  stage_rst_reg;
    logic [CW-1:0]          cur_stage_reg;
    logic                   sys_ready_reg;
    logic                   timeout_err_reg;

    logic                   rel_ok;
    logic [NUM_STAGES-1:0]  cur_sel;
    logic                   ack_hit;

    assign rel_ok = sync_reg[SYNC_STAGES-1];

    // stage_rst is a thermometer (ones on top), so the awaited stage is the
    // lowest index still... no: the highest released bit, i.e. zero with a one (or the top) above it.
    assign cur_sel = ~stage_rst_reg & ((stage_rst_reg >> 1) | TOP_BIT);
    assign ack_hit = |(seq.stage_ack & cur_sel);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
            deb_reg      <= 1'b0;
            deb_cnt_reg  <= '0;
        end else begin
            btn_meta_reg <= btn_rst;
            btn_sync_reg <= btn_meta_reg;
            if (btn_sync_reg != deb_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    deb_reg     <= btn_sync_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= HOLD;
            stage_rst_reg   <= ALL_ONES;
            cur_stage_reg   <= '0;
            sys_ready_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            hold_cnt_reg    <= '0;
            ack_tmr_reg     <= '0;
        end else if (deb_reg) begin
            // Held button keeps everything in HOLD; timeout_err survives on purpose.
            state_reg     <= HOLD;
            stage_rst_reg <= ALL_ONES;
            cur_stage_reg <= '0;
            sys_ready_reg <= 1'b0;
            hold_cnt_reg  <= '0;
            ack_tmr_reg   <= '0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (rel_ok) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            hold_cnt_reg  <= '0;
                            ack_tmr_reg   <= '0;
                            stage_rst_reg <= ALL_ONES << 1;
                            cur_stage_reg <= '0;
                            state_reg     <= WAIT_ACK;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end else begin
                        hold_cnt_reg <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit || (ack_tmr_reg == ACK_LAST)) begin
                        if (!ack_hit) begin
                            timeout_err_reg <= 1'b1;
                        end
                        ack_tmr_reg   <= '0;
                        stage_rst_reg <= stage_rst_reg << 1;
                        if (cur_stage_reg == LAST_IDX) begin
                            state_reg     <= RUN;
                            cur_stage_reg <= CW'(NUM_STAGES);
                            sys_ready_reg <= 1'b1;
                        end else begin
                            cur_stage_reg <= cur_stage_reg + 1'b1;
                        end
                    end else begin
                        ack_tmr_reg <= ack_tmr_reg + 1'b1;
                    end
                end
                RUN: begin
`ifdef RESET_SEQUENCER_ACK_LOSS_REARM_EN
                    if (!(&seq.stage_ack)) begin
                        state_reg     <= HOLD;
                        stage_rst_reg <= ALL_ONES;
                        cur_stage_reg <= '0;
                        sys_ready_reg <= 1'b0;
                        hold_cnt_reg  <= '0;
                        ack_tmr_reg   <= '0;
                    end
`else
                    state_reg <= RUN;
`endif
                end
                default: begin
                    state_reg     <= HOLD;
                    stage_rst_reg <= ALL_ONES;
                    cur_stage_reg <= '0;
                    sys_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign seq.stage_rst   = stage_rst_reg;
    assign seq.cur_stage   = cur_stage_reg;
    assign seq.sys_ready   = sys_ready_reg;
    assign seq.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, delayed acks, timeout, button, async reset, ack loss.
// Observed tuple is {stage_rst, cur_stage, sys_ready, timeout_err}, sampled at the falling edge.
module tb_reset_sequencer;
    localparam int NS = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic btn_rst = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];

    reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_sequencer #(
        .NUM_STAGES(NS),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .DEBOUNCE_CYCLES(8),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_rst(btn_rst),
        .seq(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [2:0] r, input logic [2:0] c,
                        input logic y, input logic t);
        exp_t e;
        e.tag = tag;
        e.exp = {r, c, y, t};
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [7:0] obs;
        obs = {bus.stage_rst, bus.cur_stage, bus.sys_ready, bus.timeout_err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] r, input logic [2:0] c,
                       input logic y, input logic t);
        push(tag, r, c, y, t);
        pop_check();
    endtask

    // Stage resets must deassert strictly in index order at all times.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert ((~bus.stage_rst & (bus.stage_rst << 1)) === 3'b000) else begin
                errors++;
                $error("FAIL stage_order observed=%b expected=thermometer", bus.stage_rst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stage_ack = 3'b111;

        // Power-up release with acks tied high
        repeat (5) tick();
        chk("reset_state", 3'b111, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int e = 1; e <= 17; e++) push($sformatf("pwr_edge%0d", e), 3'b111, 3'd0, 1'b0, 1'b0);
        push("pwr_edge18", 3'b110, 3'd0, 1'b0, 1'b0);
        push("pwr_edge19", 3'b100, 3'd1, 1'b0, 1'b0);
        push("pwr_edge20", 3'b000, 3'd2, 1'b0, 1'b0);
        push("pwr_edge21", 3'b000, 3'd3, 1'b1, 1'b0);
        for (int e = 1; e <= 21; e++) begin
            tick();
            pop_check();
        end

        // Delayed acks
        reset_n = 1'b0;
        tick();
        chk("dly_reset", 3'b111, 3'd0, 1'b0, 1'b0);
        bus.stage_ack = 3'b000;
        reset_n = 1'b1;
        repeat (17) tick();
        chk("dly_edge17", 3'b111, 3'd0, 1'b0, 1'b0);
        tick();
        chk("dly_stage0_rel", 3'b110, 3'd0, 1'b0, 1'b0);
        repeat (10) tick();
        chk("dly_wait0", 3'b110, 3'd0, 1'b0, 1'b0);
        bus.stage_ack[0] = 1'b1;
        tick();
        chk("dly_ack0", 3'b100, 3'd1, 1'b0, 1'b0);
        repeat (3) tick();
        chk("dly_wait1", 3'b100, 3'd1, 1'b0, 1'b0);
        bus.stage_ack[1] = 1'b1;
        tick();
        chk("dly_ack1", 3'b000, 3'd2, 1'b0, 1'b0);
        bus.stage_ack[2] = 1'b1;
        tick();
        chk("dly_ack2", 3'b000, 3'd3, 1'b1, 1'b0);

        // Ack timeout on stage 1
        reset_n = 1'b0;
        tick();
        bus.stage_ack = 3'b101;
        reset_n = 1'b1;
        repeat (18) tick();
        chk("to_stage0_rel", 3'b110, 3'd0, 1'b0, 1'b0);
        tick();
        chk("to_enter1", 3'b100, 3'd1, 1'b0, 1'b0);
        repeat (254) tick();
        chk("to_before", 3'b100, 3'd1, 1'b0, 1'b0);
        tick();
        chk("to_fire", 3'b000, 3'd2, 1'b0, 1'b1);
        tick();
        chk("to_run", 3'b000, 3'd3, 1'b1, 1'b1);

        // Button glitches then a real press
        for (int g = 0; g < 2; g++) begin
            btn_rst = 1'b1;
            repeat (5) tick();
            btn_rst = 1'b0;
            repeat (5) tick();
        end
        repeat (5) tick();
        chk("btn_glitch", 3'b000, 3'd3, 1'b1, 1'b1);
        btn_rst = 1'b1;
        repeat (10) tick();
        chk("btn_pre", 3'b000, 3'd3, 1'b1, 1'b1);
        tick();
        chk("btn_hold", 3'b111, 3'd0, 1'b0, 1'b1);
        repeat (5) tick();
        chk("btn_held", 3'b111, 3'd0, 1'b0, 1'b1);
        btn_rst = 1'b0;
        bus.stage_ack = 3'b001;
        repeat (25) tick();
        chk("btn_rel_pre", 3'b111, 3'd0, 1'b0, 1'b1);
        tick();
        chk("btn_reseq", 3'b110, 3'd0, 1'b0, 1'b1);
        tick();
        chk("btn_stage1", 3'b100, 3'd1, 1'b0, 1'b1);
        tick();

        // Asynchronous reset between edges while waiting on stage 1
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst", 3'b111, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("async_rst_hold", 3'b111, 3'd0, 1'b0, 1'b0);

        // Ack loss in RUN
        bus.stage_ack = 3'b111;
        reset_n = 1'b1;
        repeat (21) tick();
        chk("loss_run", 3'b000, 3'd3, 1'b1, 1'b0);
        bus.stage_ack = 3'b011;
        tick();
        bus.stage_ack = 3'b111;
`ifdef RESET_SEQUENCER_ACK_LOSS_REARM_EN
        chk("loss_rearm", 3'b111, 3'd0, 1'b0, 1'b0);
        tick();
        chk("loss_rearm_hold", 3'b111, 3'd0, 1'b0, 1'b0);
`else
        chk("loss_ignored", 3'b000, 3'd3, 1'b1, 1'b0);
        tick();
        chk("loss_ignored2", 3'b000, 3'd3, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumer side of the power-on reset scheme.
- Takes the board-level asynchronous active-low reset plus a raw manual reset button.
- Releases a chain of per-subsystem synchronous resets one stage at a time (display, keypad, ALU, ...), waiting for each stage's ready acknowledge before releasing the next.
- Flags when every stage is up, and reports any stage that never acknowledged.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs (1..8)
SYNC_STAGES, 2, flops in the reset-release synchronizer (>=2)
HOLD_CYCLES, 16, cycles all stages are held in reset after reset release or button release (>=1)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to change the debounced button level (>=2)
ACK_TIMEOUT, 255, max cycles waited for one stage's ack before forcing progress (>=1)

Ports:
clk  in  1  single system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset; asserts immediately, release synchronized internally
btn_rst  in  1  raw manual reset push-button, active-high, asynchronous, bouncy
stage_ack  in  NUM_STAGES  per-stage ready acknowledge, active-high, synchronous to clk
stage_rst  out  NUM_STAGES  per-stage synchronous reset, active-high
cur_stage  out  $clog2(NUM_STAGES)+1  index of stage currently awaited; NUM_STAGES in RUN
sys_ready  out  1  high when all stages released and sequence complete
timeout_err  out  1  sticky; set when any stage ack timed out

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low, named reset_n.
- reset_n low, asynchronous effect:
  - stage_rst = all ones, sys_ready = 0, timeout_err = 0, cur_stage = 0.
  - FSM = HOLD; hold counter, ack timer, debounce counter and debounced level all cleared.
  - Synchronizer chain cleared to 0.
- Release synchronizer: SYNC_STAGES flop chain shifting in 1 after reset_n rises. The FSM treats reset as active until the chain output is 1.
- Button path:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level toggles only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle clears the counter.
- FSM states: HOLD, WAIT_ACK, RUN.
- HOLD:
  - stage_rst all 1, sys_ready 0.
  - Hold counter increments only while the sync chain output is 1 and the debounced button is 0; otherwise the counter is cleared.
  - When counter == HOLD_CYCLES-1: on that edge stage_rst[0] goes 0, cur_stage = 0, ack timer cleared, state -> WAIT_ACK.
- WAIT_ACK (index k = cur_stage):
  - stage_ack[k] sampled 1: on that same edge, if k < NUM_STAGES-1 then stage_rst[k+1] goes 0 and cur_stage = k+1; else state -> RUN, cur_stage = NUM_STAGES, sys_ready = 1 on that edge.
  - Ack timer counts cycles in the current stage. Timer == ACK_TIMEOUT-1 without ack: timeout_err set; progress exactly as if acked on that edge.
  - Acks of other stages are ignored.
- RUN: holds; sys_ready = 1; stage_rst all 0.
- Debounced button rising in any state:
  - Next edge: state -> HOLD, stage_rst all 1, sys_ready 0, cur_stage 0, counters cleared.
  - timeout_err is NOT cleared by the button; only reset_n clears it.
- Latency, reset_n to stage_rst[0]: stage_rst[0] falls SYNC_STAGES+HOLD_CYCLES rising edges after the first edge sampling reset_n high.
- Stage ordering: stage_rst bits always deassert in index order. A higher index is never 0 while a lower index is 1.
- reset_n mid-sequence: immediate return to the reset values above.
- Simultaneous button press and ack on the same edge: the button wins.

Optional Feature:
RESET_SEQUENCER_ACK_LOSS_REARM_EN
- Defined: in RUN, any stage_ack bit sampled 0 restarts the sequence.
  - Next edge: HOLD, stage_rst all 1, sys_ready 0, cur_stage 0.
  - timeout_err unchanged.
- Not defined: stage_ack is ignored in RUN and HOLD; the block stays in RUN until a button press or reset_n.

Test Plan:
- Power-up release: defaults, reset_n low 5 cycles then high, stage_ack tied to all ones -> stage_rst = 3'b111 until edge 18 after release; then 3'b110, 3'b100, 3'b000 on 3 consecutive edges; sys_ready = 1 with the last; timeout_err = 0.
- Delayed acks: ack[0] raised 10 cycles after stage_rst[0] falls, ack[1] after 3 cycles -> stage_rst[1] falls on the edge sampling ack[0]; cur_stage steps 0, 1, 2, 3.
- Timeout: ack[1] stuck 0, ACK_TIMEOUT = 255 -> timeout_err rises exactly 255 cycles after entering stage 1; stage_rst[2] falls the same edge; the sequence completes and timeout_err remains 1.
- Button debounce: DEBOUNCE_CYCLES = 8, in RUN; 5-cycle glitch pulses -> no change; held high 8 cycles -> stage_rst = all ones and sys_ready = 0; after release plus 8 stable-low cycles plus HOLD_CYCLES -> re-sequence.
- Async reset mid-sequence: reset_n pulled low between clock edges while in WAIT_ACK, stage 1 -> stage_rst = all ones and timeout_err = 0 before the next edge.
- With RESET_SEQUENCER_ACK_LOSS_REARM_EN defined: in RUN drop ack[2] for 1 cycle -> HOLD on the next edge; without the macro -> sys_ready stays 1.
